vec_seq: RTL and testbench
==========================

# vec_seq

Programmable stimulus sequencer that drives the three single-bit inputs of the `test2` combinational block. A host loads (vector, dwell) pairs into an internal FIFO, then pulses `start`. The block then replays each 3-bit vector for a programmed number of cycles, so a sequence runs in hardware instead of as `#delay` statements in a bench. It sits directly upstream of `test2`, with `drv1/drv2/drv3` wired to `in1/in2/in3`.

## Interface
- `DEPTH`, 8: FIFO entries; power of two, minimum 2.
- `DWELL_W`, 8: width of the dwell field.

- `clk`  in  1  sole clock; all logic is on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `wr_valid`  in  1  host offers an entry.
- `wr_ready`  out  1  FIFO can accept an entry (not full).
- `wr_vec`  in  3  vector; bit2→drv1, bit1→drv2, bit0→drv3.
- `wr_dwell`  in  DWELL_W  extra hold cycles; the vector is held `wr_dwell`+1 cycles.
- `start`  in  1  begins playback (single-cycle pulse).
- `busy`  out  1  high while in RUN.
- `done`  out  1  one-cycle pulse when the FIFO drains.
- `drv1`, `drv2`, `drv3`  out  1 each  stimulus outputs to `test2`.

## Operation
- FIFO: `DEPTH` × (3+`DWELL_W`).
  - Push when `wr_valid && wr_ready`.
  - `wr_ready` = !full; registered count; no push-through at full, even if a pop occurs in the same cycle.
  - Pushes are legal in every state, including RUN.
- FSM has three states: IDLE, RUN, DONE.
- IDLE:
  - `start` with FIFO non-empty → RUN; pop head; load `drv*`; dwell counter ← head dwell.
  - `start` with FIFO empty is ignored and the FSM stays in IDLE.
- RUN:
  - While the counter ≠ 0, decrement it.
  - When the counter = 0 and the FIFO is non-empty: pop the next entry, load `drv*`, reload the counter.
  - When the counter = 0 and the FIFO is empty → DONE.
  - `start` is ignored.
- DONE: lasts one cycle; `done`=1, then → IDLE.
- `drv*` hold their last vector in DONE and IDLE; they change only on a pop or on reset.
- A vector pushed during RUN before the counter reaches 0 is played seamlessly.
- Reset mid-run: FIFO is flushed, FSM goes to IDLE, and all outputs return to their reset values on the next edge.
- Reset values: `drv1/2/3`=0, `busy`=0, `done`=0, `wr_ready`=1, FIFO count=0.

## Timing
- All outputs are registered.
- `start` sampled at edge E0 → at E1: first vector on `drv*`, `busy`=1.
- A vector loaded at edge Ek with dwell d is replaced at edge Ek+d+1.
- Last vector, loaded at EL with dwell d: at EL+d+1, `busy`=0 and `done`=1; at EL+d+2, `done`=0.
- Push at edge E: visible in the count and `wr_ready` from E+1; the entry can be popped from E+1 onward.
- A push and a pop in the same cycle leave the count unchanged.
- The dwell counter is `DWELL_W` bits unsigned, so the maximum hold is 2^`DWELL_W` cycles.

## Configuration
- `VEC_SEQ_CNT_EN` defined:
  - Adds output `vec_cnt` (8 bits, reset 0), the number of vectors issued.
  - Cleared on an accepted `start`; increments on each pop in IDLE/RUN.
  - Saturates at 255.
- `VEC_SEQ_CNT_EN` undefined: the port and its counter are absent; all other behaviour is identical.

## Test plan
- Reset check: after `rst`, `drv`=000, `busy`=0, `done`=0, `wr_ready`=1.
- Sequence playback:
  - Load 010/9, 110/9, 000/9, 100/9, 111/19, then `start`.
  - `drv` changes every 10 cycles in that order; 111 holds 20 cycles.
  - `done` pulses exactly 60 cycles after the first vector appears; `drv` stays 111 afterwards.
- FIFO full:
  - Push 8 entries with `wr_valid` held → `wr_ready`=0 after the 8th.
  - A 9th offer is not accepted and its data is absent from playback.
- Empty start: `start` with an empty FIFO → `busy` stays 0 and no `done` pulse.
- Refill during RUN:
  - Load 101/0, `start`; push 011/3 on the cycle the first vector appears.
  - `drv`=101 for 1 cycle, then 011 for 4 cycles, then `done`.
- Mid-run reset, then counter check:
  - Assert `rst` during the 2nd vector → next edge `drv`=000, `busy`=0, FIFO empty.
  - With `VEC_SEQ_CNT_EN` defined, repeat the sequence-playback scenario → `vec_cnt`=5.

Source files
------------

// File: rtl/vec_seq.sv
// Stimulus sequencer: replays FIFO-loaded (vector, dwell) pairs onto drv1/drv2/drv3.
// Optional issued-vector counter output vec_cnt is enabled by defining VEC_SEQ_CNT_EN.
module vec_seq #(
    parameter int unsigned DEPTH   = 8,
    parameter int unsigned DWELL_W = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               wr_valid,
    output logic               wr_ready,
    input  logic [2:0]         wr_vec,
    input  logic [DWELL_W-1:0] wr_dwell,
    input  logic               start,
    output logic               busy,
    output logic               done,
    output logic               drv1,
    output logic               drv2,
    output logic               drv3
`ifdef VEC_SEQ_CNT_EN
    ,
    output logic [7:0]         vec_cnt
`endif
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = PTR_W + 1;

    typedef struct packed {
        logic [2:0]         vec;
        logic [DWELL_W-1:0] dwell;
    } entry_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    entry_t             mem [DEPTH];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [CNT_W-1:0]   count;
    logic [DWELL_W-1:0] dwell_cnt;
    state_t             state;

    logic               push_c;
    logic               pop_c;
    logic               empty_c;
    entry_t             head_c;
    logic [CNT_W-1:0]   count_next_c;

    assign push_c  = wr_valid && wr_ready;
    assign empty_c = (count == '0);
    assign head_c  = mem[rd_ptr];

    // Pop on an accepted start, or when the current vector's dwell has expired.
    always_comb begin
        pop_c = 1'b0;
        case (state)
            IDLE:    pop_c = start && !empty_c;
            RUN:     pop_c = (dwell_cnt == '0) && !empty_c;
            default: pop_c = 1'b0;
        endcase
    end

    assign count_next_c = count + CNT_W'(push_c) - CNT_W'(pop_c);

    // Storage needs no reset: the pointers and count define what is valid.
    always_ff @(posedge clk) begin
        if (push_c) begin
            mem[wr_ptr] <= {wr_vec, wr_dwell};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            wr_ready <= 1'b1;
        end else begin
            if (push_c) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop_c) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            count    <= count_next_c;
            wr_ready <= (count_next_c != CNT_W'(DEPTH));
        end
    end

    // Playback FSM with registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            busy      <= 1'b0;
            done      <= 1'b0;
            drv1      <= 1'b0;
            drv2      <= 1'b0;
            drv3      <= 1'b0;
            dwell_cnt <= '0;
`ifdef VEC_SEQ_CNT_EN
            vec_cnt   <= 8'd0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (pop_c) begin
                        state              <= RUN;
                        busy               <= 1'b1;
                        {drv1, drv2, drv3} <= head_c.vec;
                        dwell_cnt          <= head_c.dwell;
`ifdef VEC_SEQ_CNT_EN
                        vec_cnt            <= 8'd1;
`endif
                    end
                end
                RUN: begin
                    if (dwell_cnt != '0) begin
                        dwell_cnt <= dwell_cnt - DWELL_W'(1);
                    end else if (pop_c) begin
                        {drv1, drv2, drv3} <= head_c.vec;
                        dwell_cnt          <= head_c.dwell;
`ifdef VEC_SEQ_CNT_EN
                        if (vec_cnt != 8'd255) begin
                            vec_cnt <= vec_cnt + 8'd1;
                        end
`endif
                    end else begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_vec_seq.sv
// Directed bench for vec_seq: table-driven playback plus hand-written corner sequences.
module tb_vec_seq;

    logic       clk = 1'b0;
    logic       rst;
    logic       wr_valid;
    logic       wr_ready;
    logic [2:0] wr_vec;
    logic [7:0] wr_dwell;
    logic       start;
    logic       busy;
    logic       done;
    logic       drv1;
    logic       drv2;
    logic       drv3;
`ifdef VEC_SEQ_CNT_EN
    logic [7:0] vec_cnt;
`endif

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [2:0] vec;
        logic [7:0] dwell;
        logic [2:0] exp_drv;
        int         exp_hold;
    } rec_t;

    rec_t play [5];

    vec_seq #(.DEPTH(8), .DWELL_W(8)) dut (
        .clk      (clk),
        .rst      (rst),
        .wr_valid (wr_valid),
        .wr_ready (wr_ready),
        .wr_vec   (wr_vec),
        .wr_dwell (wr_dwell),
        .start    (start),
        .busy     (busy),
        .done     (done),
        .drv1     (drv1),
        .drv2     (drv2),
        .drv3     (drv3)
`ifdef VEC_SEQ_CNT_EN
        ,
        .vec_cnt  (vec_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int drv_now();
        return int'({drv1, drv2, drv3});
    endfunction

    task automatic push(input logic [2:0] v, input logic [7:0] d);
        wr_valid = 1'b1;
        wr_vec   = v;
        wr_dwell = d;
        tick();
        wr_valid = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Loads the five-entry table, starts it and checks every held cycle plus the done pulse.
    task automatic run_playback();
        for (int i = 0; i < 5; i++) push(play[i].vec, play[i].dwell);
        pulse_start();
        for (int i = 0; i < 5; i++) begin
            for (int c = 0; c < play[i].exp_hold; c++) begin
                check($sformatf("play_drv[%0d]", i), drv_now(), int'(play[i].exp_drv));
                check($sformatf("play_busy[%0d]", i), int'(busy), 1);
                check($sformatf("play_nodone[%0d]", i), int'(done), 0);
                tick();
            end
        end
        check("play_done", int'(done), 1);
        check("play_busy_end", int'(busy), 0);
        check("play_drv_end", drv_now(), 3'b111);
        tick();
        check("play_done_clr", int'(done), 0);
        check("play_drv_hold", drv_now(), 3'b111);
    endtask

    initial begin
        play[0] = '{vec: 3'b010, dwell: 8'd9,  exp_drv: 3'b010, exp_hold: 10};
        play[1] = '{vec: 3'b110, dwell: 8'd9,  exp_drv: 3'b110, exp_hold: 10};
        play[2] = '{vec: 3'b000, dwell: 8'd9,  exp_drv: 3'b000, exp_hold: 10};
        play[3] = '{vec: 3'b100, dwell: 8'd9,  exp_drv: 3'b100, exp_hold: 10};
        play[4] = '{vec: 3'b111, dwell: 8'd19, exp_drv: 3'b111, exp_hold: 20};

        rst      = 1'b1;
        wr_valid = 1'b0;
        wr_vec   = 3'b000;
        wr_dwell = 8'd0;
        start    = 1'b0;
        do_reset();

        check("rst_drv", drv_now(), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_wr_ready", int'(wr_ready), 1);

        run_playback();

        // FIFO full: eight entries of vec i / dwell 1, then a rejected ninth offer.
        wr_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            wr_vec   = 3'(i);
            wr_dwell = 8'd1;
            tick();
        end
        check("full_wr_ready", int'(wr_ready), 0);
        wr_vec   = 3'b110;
        wr_dwell = 8'd3;
        tick();
        wr_valid = 1'b0;
        check("full_still", int'(wr_ready), 0);
        pulse_start();
        for (int i = 0; i < 8; i++) begin
            for (int c = 0; c < 2; c++) begin
                check($sformatf("full_drv[%0d]", i), drv_now(), i);
                tick();
            end
        end
        check("full_done", int'(done), 1);
        check("full_no_ninth", drv_now(), 7);
        check("full_ready_back", int'(wr_ready), 1);
        tick();

        // Empty start must be ignored.
        pulse_start();
        for (int c = 0; c < 4; c++) begin
            check("empty_busy", int'(busy), 0);
            check("empty_done", int'(done), 0);
            tick();
        end

        // Refill: push 011/3 on the edge that loads the first vector 101/0.
        push(3'b101, 8'd0);
        start    = 1'b1;
        wr_valid = 1'b1;
        wr_vec   = 3'b011;
        wr_dwell = 8'd3;
        tick();
        start    = 1'b0;
        wr_valid = 1'b0;
        check("refill_first", drv_now(), 3'b101);
        tick();
        for (int c = 0; c < 4; c++) begin
            check("refill_second", drv_now(), 3'b011);
            check("refill_busy", int'(busy), 1);
            tick();
        end
        check("refill_done", int'(done), 1);
        tick();

        // Mid-run reset during the second vector.
        push(3'b001, 8'd4);
        push(3'b010, 8'd4);
        push(3'b100, 8'd4);
        pulse_start();
        repeat (6) tick();
        check("mid_second", drv_now(), 3'b010);
        rst = 1'b1;
        tick();
        check("mid_rst_drv", drv_now(), 0);
        check("mid_rst_busy", int'(busy), 0);
        check("mid_rst_ready", int'(wr_ready), 1);
        rst = 1'b0;
        pulse_start();
        check("mid_flushed", int'(busy), 0);
        tick();
        check("mid_no_done", int'(done), 0);

`ifdef VEC_SEQ_CNT_EN
        run_playback();
        check("vec_cnt", int'(vec_cnt), 5);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
